cp0_regfile: RTL

- Coprocessor-0 register file at the receiving end of the exception unit's commit interface.
- Consumes wr_exp/exp_code/epc/badvaddr/clear_exl and MTC0 writes, and holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Drives epc_out, allow_int and interrupt_flag back to the exception unit, and supplies MFC0 read data to the pipeline.

---
 rtl/cp0_regfile_if.sv | 33 +++
 rtl/cp0_regfile.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile_if.sv
// Commit/MTC0/MFC0 bundle between the exception unit, pipeline and the CP0 register file.
interface cp0_regfile_if;
  logic [5:0]  hw_int;
  logic        wr_exp;
  logic [4:0]  exp_code;
  logic [31:0] epc;
  logic        in_delayslot;
  logic        badvaddr_we;
  logic [31:0] badvaddr;
  logic        clear_exl;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic [31:0] epc_out;
  logic        allow_int;
  logic [7:0]  interrupt_flag;
  logic [31:0] status_out;
  logic [31:0] cause_out;

  modport master (
    output hw_int, wr_exp, exp_code, epc, in_delayslot, badvaddr_we, badvaddr,
           clear_exl, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    input  mfc0_rdata, epc_out, allow_int, interrupt_flag, status_out, cause_out
  );

  modport slave (
    input  hw_int, wr_exp, exp_code, epc, in_delayslot, badvaddr_we, badvaddr,
           clear_exl, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    output mfc0_rdata, epc_out, allow_int, interrupt_flag, status_out, cause_out
  );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, BadVAddr and, with CP0_TIMER_EN defined, Count/Compare.
// Without CP0_TIMER_EN the timer registers are absent and addresses 9/11 read as zero.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic           clk,
  input  logic           resetn,
  cp0_regfile_if.slave   bus
);

  localparam logic [4:0] A_BADV   = 5'd8;
  localparam logic [4:0] A_COUNT  = 5'd9;
  localparam logic [4:0] A_CMP    = 5'd11;
  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [5:0]  hw_int_q;
  logic        mtc0_ok_s;
  logic        ti_s;
  logic [7:0]  ip_s;
  logic [31:0] status_s;
  logic [31:0] cause_s;
  logic [31:0] rdata_s;

  // A committing exception swallows any MTC0 issued in the same cycle.
  assign mtc0_ok_s = bus.mtc0_we & ~bus.wr_exp;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;

  // Timer next state: half-rate Count, Compare match sets sticky TI.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    tick_d    = ~tick_q;
    ti_d      = ti_q;
    if (mtc0_ok_s && (bus.mtc0_addr == A_COUNT)) begin
      count_d = bus.mtc0_wdata;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if (mtc0_ok_s && (bus.mtc0_addr == A_CMP)) begin
      compare_d = bus.mtc0_wdata;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end else begin
      ti_d = ti_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign ti_s = ti_q;
`else
  assign ti_s = 1'b0;
`endif

  // Status/Cause/EPC/BadVAddr next state with commit/ERET/MTC0 priority.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_d      = exc_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (mtc0_ok_s && (bus.mtc0_addr == A_STATUS)) begin
      im_d  = bus.mtc0_wdata[15:8];
      exl_d = bus.mtc0_wdata[1];
      ie_d  = bus.mtc0_wdata[0];
    end else begin
      im_d = im_q;
    end
    if (mtc0_ok_s && (bus.mtc0_addr == A_CAUSE)) begin
      ip_sw_d = bus.mtc0_wdata[9:8];
    end else begin
      ip_sw_d = ip_sw_q;
    end
    if (mtc0_ok_s && (bus.mtc0_addr == A_EPC)) begin
      epc_d = bus.mtc0_wdata;
    end else begin
      epc_d = epc_q;
    end
    // EXL override after the MTC0 so ERET wins over a same-cycle Status write.
    if (bus.wr_exp) begin
      exl_d = 1'b1;
      exc_d = bus.exp_code;
      if (!exl_q) begin
        epc_d = bus.in_delayslot ? (bus.epc - 32'd4) : bus.epc;
        bd_d  = bus.in_delayslot;
      end else begin
        bd_d = bd_q;
      end
    end else if (bus.clear_exl) begin
      exl_d = 1'b0;
    end else begin
      exc_d = exc_q;
    end
    if (bus.badvaddr_we) begin
      badvaddr_d = bus.badvaddr;
    end else begin
      badvaddr_d = badvaddr_q;
    end
  end

  // Architectural state and the interrupt-line synchroniser.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im_q       <= STATUS_RESET[15:8];
      exl_q      <= STATUS_RESET[1];
      ie_q       <= STATUS_RESET[0];
      bd_q       <= 1'b0;
      ip_sw_q    <= 2'b00;
      exc_q      <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      hw_int_q   <= 6'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      exc_q      <= exc_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      hw_int_q   <= bus.hw_int;
    end
  end

  assign ip_s     = {hw_int_q[5] | ti_s, hw_int_q[4:0], ip_sw_q};
  assign status_s = {9'd0, STATUS_RESET[22], 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_s  = {bd_q, ti_s, 14'd0, ip_s, 1'b0, exc_q, 2'b00};

  // MFC0 read mux, no bypass of pending writes.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.mfc0_addr)
      A_BADV:   rdata_s = badvaddr_q;
`ifdef CP0_TIMER_EN
      A_COUNT:  rdata_s = count_q;
      A_CMP:    rdata_s = compare_q;
`endif
      A_STATUS: rdata_s = status_s;
      A_CAUSE:  rdata_s = cause_s;
      A_EPC:    rdata_s = epc_q;
      default:  rdata_s = 32'd0;
    endcase
  end

  assign bus.mfc0_rdata     = rdata_s;
  assign bus.epc_out        = (mtc0_ok_s && (bus.mtc0_addr == A_EPC)) ? bus.mtc0_wdata : epc_q;
  assign bus.allow_int      = ie_q & ~exl_q;
  assign bus.interrupt_flag = ip_s & im_q;
  assign bus.status_out     = status_s;
  assign bus.cause_out      = cause_s;

endmodule
